// File: rtl/serial_addsub_ctrl_if.sv
// Handshake and operand/result bundle between a requesting FSM (master)
// and the bit-serial add/subtract controller (slave).
interface serial_addsub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, zero
  );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: one 1-bit add/sub cell reused over
// WIDTH cycles, LSB first, with a start/busy/done handshake.
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  serial_addsub_ctrl_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic             op_q;
  logic             c_q;
  logic [WIDTH-2:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             zero_q;
  logic             busy_q;
  logic             done_q;

  logic             ai;
  logic             bi;
  logic             p;
  logic             bit_d;
  logic             c_d;
  logic [WIDTH-1:0] acc_d;

  // Shared 1-bit cell: the sum and difference bits are identical; only the
  // carry/borrow recurrence depends on op.
  always_comb begin
    ai    = a_sh_q[0];
    bi    = b_sh_q[0];
    p     = ai ^ bi;
    bit_d = p ^ c_q;
    c_d   = op_q ? ((~ai & bi) | (c_q & ~p)) : ((ai & bi) | (c_q & p));
    acc_d = {bit_d, acc_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      op_q     <= 1'b0;
      c_q      <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            op_q    <= bus.op;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
          c_q    <= c_d;
          acc_q  <= acc_d[WIDTH-1:1];
          cnt_q  <= cnt_q + CNT_W'(1);
          // Results are only published once the last bit is in, never partially.
          if (cnt_q == LAST_BIT) begin
            result_q <= acc_d;
            cout_q   <= c_d;
            zero_q   <= (acc_d == '0);
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.zero   = zero_q;

endmodule
